tune_sequencer: RTL and testbench

TUNE_SEQUENCER -- requirements
Module: tune_sequencer

---
 rtl/tune_sequencer.sv | 133 +++++++++++++
 tb/tb_tune_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tune_sequencer.sv
// Turns dial steps and direct set commands into clamped NCO phase increments.
// Set: 2 cycles to offer; dial: 4 cycles from IDLE; offers wait on phase_ready, and dial steps accumulate meanwhile.
module tune_sequencer #(
  parameter int PHASE_W   = 27,
  parameter int STEP_INC  = 83_886,
  parameter int MIN_INC   = 4_194_304,
  parameter int MAX_INC   = 14_680_064,
  parameter int RESET_INC = 8_388_608
) (
  input  logic               aclk,
  input  logic               reset,
  input  logic [7:0]         dial_inc,
  input  logic               dial_valid,
  input  logic [PHASE_W-1:0] set_inc,
  input  logic               set_valid,
  output logic               set_ready,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               phase_valid,
  input  logic               phase_ready,
  output logic               busy,
  output logic               clamped
);

  localparam int TW = PHASE_W + 14;
  localparam logic signed [TW-1:0] L_MIN  = TW'(MIN_INC);
  localparam logic signed [TW-1:0] L_MAX  = TW'(MAX_INC);
  localparam logic signed [TW-1:0] L_STEP = TW'(STEP_INC);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_MUL, S_CLAMP, S_ISSUE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic signed [11:0]    r_pend;
  logic signed [11:0]    r_take;
  logic signed [11:0]    w_pend_base;
  logic signed [11:0]    w_pend_nxt;
  logic signed [12:0]    w_pend_sum;
  logic signed [TW-1:0]  r_target;
  logic signed [TW-1:0]  w_target_mul;
  logic [PHASE_W-1:0]    w_phase_clamped;
  logic                  w_limit;
  logic                  w_take_load;
  logic                  w_set_accept;
  logic [PHASE_W-1:0]    r_phase_inc;
  logic                  r_phase_valid;
  logic                  r_clamped;

  always_ff @(posedge aclk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    set_ready    = 1'b0;
    w_set_accept = 1'b0;
    w_take_load  = 1'b0;
    case (r_state)
      S_INIT:  w_state_nxt = S_ISSUE;
      S_IDLE: begin
        if (set_valid) begin
          set_ready    = !reset;
          w_set_accept = 1'b1;
          w_state_nxt  = S_CLAMP;
        end else if (r_pend != 12'sd0) begin
          w_take_load = 1'b1;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL:   w_state_nxt = S_CLAMP;
      S_CLAMP: w_state_nxt = S_ISSUE;
      S_ISSUE: if (phase_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Dial steps land on top of whatever is still pending; a take empties pend first.
  always_comb begin
    w_pend_base = w_take_load ? 12'sd0 : r_pend;
    w_pend_sum  = $signed({w_pend_base[11], w_pend_base}) + $signed({{5{dial_inc[7]}}, dial_inc});
    w_pend_nxt  = w_pend_base;
    if (dial_valid && (dial_inc != 8'd0)) begin
      if (w_pend_sum > 13'sh07FF)      w_pend_nxt = 12'sh7FF;
      else if (w_pend_sum < 13'sh1800) w_pend_nxt = 12'sh800;
      else                             w_pend_nxt = w_pend_sum[11:0];
    end
  end

  // Wide enough that phase + 2047 full steps can never wrap.
  assign w_target_mul = $signed({{(TW-PHASE_W){1'b0}}, r_phase_inc})
                      + $signed({{(TW-12){r_take[11]}}, r_take}) * L_STEP;

  always_comb begin
    w_limit         = 1'b1;
    w_phase_clamped = r_target[PHASE_W-1:0];
    if (r_target < L_MIN)      w_phase_clamped = PHASE_W'(MIN_INC);
    else if (r_target > L_MAX) w_phase_clamped = PHASE_W'(MAX_INC);
    else                       w_limit = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_pend        <= 12'sd0;
      r_take        <= 12'sd0;
      r_target      <= '0;
      r_phase_inc   <= PHASE_W'(RESET_INC);
      r_phase_valid <= 1'b0;
      r_clamped     <= 1'b0;
    end else begin
      r_pend    <= w_pend_nxt;
      r_clamped <= 1'b0;
      if (w_take_load) r_take <= r_pend;
      if (w_set_accept)          r_target <= $signed({{(TW-PHASE_W){1'b0}}, set_inc});
      else if (r_state == S_MUL) r_target <= w_target_mul;
      case (r_state)
        S_INIT:  r_phase_valid <= 1'b1;
        S_CLAMP: begin
          r_phase_inc   <= w_phase_clamped;
          r_phase_valid <= 1'b1;
          r_clamped     <= w_limit;
        end
        S_ISSUE: if (phase_ready) r_phase_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign phase_inc   = r_phase_inc;
  assign phase_valid = r_phase_valid;
  assign clamped     = r_clamped;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer: reset, dial/set paths, stall, priority, saturation, abort.
module tb_tune_sequencer;

  logic        aclk = 1'b0;
  logic        reset;
  logic [7:0]  dial_inc;
  logic        dial_valid;
  logic [26:0] set_inc;
  logic        set_valid;
  logic        set_ready;
  logic [26:0] phase_inc;
  logic        phase_valid;
  logic        phase_ready;
  logic        busy;
  logic        clamped;

  int checks = 0;
  int errors = 0;

  tune_sequencer dut (
    .aclk(aclk), .reset(reset), .dial_inc(dial_inc), .dial_valid(dial_valid),
    .set_inc(set_inc), .set_valid(set_valid), .set_ready(set_ready),
    .phase_inc(phase_inc), .phase_valid(phase_valid), .phase_ready(phase_ready),
    .busy(busy), .clamped(clamped)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (phase_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; phase_ready = 1'b1; set_valid = 1'b1; set_inc = 27'd5_000_000;
    dial_valid = 1'b0; dial_inc = 8'd0;
    repeat (3) tick();
    checks++; if (phase_inc !== 27'd8_388_608) begin errors++; $display("FAIL rst_phase_inc got %0d want 8388608", phase_inc); end
    checks++; if (phase_valid !== 1'b0) begin errors++; $display("FAIL rst_phase_valid got %b want 0", phase_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
    checks++; if (clamped !== 1'b0) begin errors++; $display("FAIL rst_clamped got %b want 0", clamped); end
    checks++; if (set_ready !== 1'b0) begin errors++; $display("FAIL rst_set_ready got %b want 0", set_ready); end
    reset = 1'b0; set_valid = 1'b0;
    tick();
    checks++; if (phase_valid !== 1'b1 || phase_inc !== 27'd8_388_608) begin errors++; $display("FAIL init_offer got v=%b inc=%0d want v=1 inc=8388608", phase_valid, phase_inc); end
    tick();
    checks++; if (phase_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL init_done got v=%b busy=%b want v=0 busy=0", phase_valid, busy); end
  endtask

  task automatic test_dial_step();
    dial_valid = 1'b1; dial_inc = 8'd3;
    tick();
    dial_valid = 1'b0; dial_inc = 8'd0;
    tick(); tick();
    checks++; if (phase_valid !== 1'b0) begin errors++; $display("FAIL dial_early got v=%b want 0 at N+3", phase_valid); end
    tick();
    checks++; if (phase_valid !== 1'b1 || phase_inc !== 27'd8_640_266) begin errors++; $display("FAIL dial_n4 got v=%b inc=%0d want v=1 inc=8640266", phase_valid, phase_inc); end
    checks++; if (clamped !== 1'b0) begin errors++; $display("FAIL dial_clamped got %b want 0", clamped); end
    tick();
    checks++; if (phase_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dial_done got v=%b busy=%b want 0 0", phase_valid, busy); end
  endtask

  task automatic test_set_clamp();
    set_valid = 1'b1; set_inc = 27'd20_000_000;
    #1;
    checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL set_ready got %b want 1", set_ready); end
    tick();
    set_valid = 1'b0;
    #1;
    checks++; if (set_ready !== 1'b0 || phase_valid !== 1'b0) begin errors++; $display("FAIL set_n1 got rdy=%b v=%b want 0 0", set_ready, phase_valid); end
    tick();
    checks++; if (phase_valid !== 1'b1 || phase_inc !== 27'd14_680_064) begin errors++; $display("FAIL set_n2 got v=%b inc=%0d want v=1 inc=14680064", phase_valid, phase_inc); end
    checks++; if (clamped !== 1'b1) begin errors++; $display("FAIL set_clamped got %b want 1", clamped); end
    tick();
    checks++; if (clamped !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL set_pulse got clamped=%b busy=%b want 0 0", clamped, busy); end
  endtask

  task automatic test_set_equal();
    set_valid = 1'b1; set_inc = 27'd14_680_064;
    tick();
    set_valid = 1'b0;
    tick();
    checks++; if (phase_valid !== 1'b1 || phase_inc !== 27'd14_680_064 || clamped !== 1'b0) begin errors++; $display("FAIL set_equal got v=%b inc=%0d cl=%b want 1 14680064 0", phase_valid, phase_inc, clamped); end
    tick();
  endtask

  task automatic test_dial_zero();
    bit seen;
    seen = 1'b0;
    dial_valid = 1'b1; dial_inc = 8'd0;
    tick();
    dial_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (phase_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL dial_zero got activity=1 want 0"); end
  endtask

  task automatic test_stall();
    bit ok;
    phase_ready = 1'b0;
    set_valid = 1'b1; set_inc = 27'd10_000_000;
    tick();
    set_valid = 1'b0;
    tick();
    checks++; if (phase_valid !== 1'b1 || phase_inc !== 27'd10_000_000) begin errors++; $display("FAIL stall_first got v=%b inc=%0d want 1 10000000", phase_valid, phase_inc); end
    for (int i = 0; i < 10; i++) begin
      dial_valid = (i < 5); dial_inc = (i < 5) ? 8'd1 : 8'd0;
      tick();
      checks++; if (phase_valid !== 1'b1 || phase_inc !== 27'd10_000_000) begin errors++; $display("FAIL stall_hold[%0d] got v=%b inc=%0d want 1 10000000", i, phase_valid, phase_inc); end
    end
    dial_valid = 1'b0; dial_inc = 8'd0;
    phase_ready = 1'b1;
    tick();
    checks++; if (phase_valid !== 1'b0) begin errors++; $display("FAIL stall_release got v=%b want 0", phase_valid); end
    wait_valid(8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_second_timeout got no offer want offer within 8 cycles"); end
    checks++; if (phase_inc !== 27'd10_419_430) begin errors++; $display("FAIL stall_second got %0d want 10419430", phase_inc); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    set_valid = 1'b1; set_inc = 27'd9_000_000;
    dial_valid = 1'b1; dial_inc = 8'hFE;
    #1;
    checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL b2b_set_ready got %b want 1", set_ready); end
    tick();
    set_valid = 1'b0; dial_valid = 1'b0; dial_inc = 8'd0;
    tick();
    checks++; if (phase_valid !== 1'b1 || phase_inc !== 27'd9_000_000) begin errors++; $display("FAIL b2b_set got v=%b inc=%0d want 1 9000000", phase_valid, phase_inc); end
    wait_valid(8, ok);
    checks++; if (!ok || phase_inc !== 27'd8_832_228) begin errors++; $display("FAIL b2b_dial got ok=%b inc=%0d want 1 8832228", ok, phase_inc); end
    tick();
  endtask

  task automatic test_saturation();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      phase_ready = 1'b0;
      set_valid = 1'b1; set_inc = 27'd10_000_000;
      tick();
      set_valid = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) begin
        dial_valid = 1'b1; dial_inc = 8'h80;
        tick();
      end
      dial_valid = 1'b0; dial_inc = 8'd0;
      if (pass == 0) begin
        checks++; if (dut.r_pend !== 12'sh800) begin errors++; $display("FAIL sat_pend got %0d want -2048", dut.r_pend); end
      end else begin
        for (int i = 0; i < 16; i++) begin
          dial_valid = 1'b1; dial_inc = 8'h7F;
          tick();
        end
        dial_valid = 1'b0; dial_inc = 8'd0;
      end
      phase_ready = 1'b1;
      tick();
      wait_valid(8, ok);
      if (pass == 0) begin
        checks++; if (!ok || phase_inc !== 27'd4_194_304 || clamped !== 1'b1) begin errors++; $display("FAIL sat_min got ok=%b inc=%0d cl=%b want 1 4194304 1", ok, phase_inc, clamped); end
      end else begin
        checks++; if (!ok || phase_inc !== 27'd8_657_824 || clamped !== 1'b0) begin errors++; $display("FAIL sat_recover got ok=%b inc=%0d cl=%b want 1 8657824 0", ok, phase_inc, clamped); end
      end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    seen = 1'b0;
    dial_valid = 1'b1; dial_inc = 8'd3;
    tick();
    dial_valid = 1'b0; dial_inc = 8'd0;
    tick();
    reset = 1'b1; dial_valid = 1'b1; dial_inc = 8'd5;
    tick();
    checks++; if (phase_inc !== 27'd8_388_608 || phase_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_rst got inc=%0d v=%b busy=%b want 8388608 0 1", phase_inc, phase_valid, busy); end
    reset = 1'b0; dial_valid = 1'b0; dial_inc = 8'd0;
    tick();
    checks++; if (phase_valid !== 1'b1 || phase_inc !== 27'd8_388_608) begin errors++; $display("FAIL abort_init got v=%b inc=%0d want 1 8388608", phase_valid, phase_inc); end
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (phase_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_discard got activity=1 want 0"); end
  endtask

  initial begin
    reset = 1'b1; dial_inc = 8'd0; dial_valid = 1'b0;
    set_inc = 27'd0; set_valid = 1'b0; phase_ready = 1'b1;
    test_reset();
    test_dial_step();
    test_set_clamp();
    test_set_equal();
    test_dial_zero();
    test_stall();
    test_back_to_back();
    test_saturation();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
